// File: rtl/hazard_ctrl_if.sv
// Bundles the pipeline-facing signals of the hazard controller.
// The pipeline (master) drives register numbers and stage status. The
// hazard controller (slave) returns stage enables, forwarding selects and
// debug information.
// Memory handshake: MemReqM is the valid side and is held for as long as the
// access is outstanding. MemReadyM is the ready side. The access completes
// in the first cycle in which both are high. It may complete in the same
// cycle it is first requested.
interface hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic             ResultSrcE0, RegWriteM, RegWriteW, PCSrcE;
  logic             MemReqM, MemReadyM;
  logic             StallF, StallD, StallE, StallM;
  logic             FlushD, FlushE, FlushW;
  logic [1:0]       ForwardAE, ForwardBE;
  logic             MemErr;
  logic [CNT_W-1:0] StallCnt, FlushCnt;
  logic [1:0]       dbg_state;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    output ResultSrcE0, RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM,
    input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
    input  ForwardAE, ForwardBE, MemErr, StallCnt, FlushCnt, dbg_state
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    input  ResultSrcE0, RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM,
    output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
    output ForwardAE, ForwardBE, MemErr, StallCnt, FlushCnt, dbg_state
  );
endinterface

// File: rtl/hazard_ctrl_unit.sv
// Central hazard controller for a 5-stage pipeline.
// - Stall and flush enables for the IF/ID, ID/EX, EX/MEM and MEM/WB registers.
// - ALU operand forwarding selects for Execute.
// - A RUN / MEM_WAIT / ERROR sequencer for multi-cycle data-memory accesses.
// - Saturating stall and flush event counters.
// dbg_state encoding: 0 = RUN, 1 = MEM_WAIT, 2 = ERROR.
module hazard_ctrl_unit #(
  parameter int WAIT_MAX = 16,
  parameter int CNT_W    = 32
) (
  input logic          clk,
  input logic          rst,
  hazard_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  localparam logic [7:0] WAIT_LIM = 8'(WAIT_MAX);

  state_t           state, state_nxt;
  logic [7:0]       wait_cnt, wait_cnt_nxt;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic             mem_stall, lw_stall;
  logic             stall_f, stall_d, stall_e, stall_m;
  logic             flush_d, flush_e, flush_w;
  logic [1:0]       fwd_a, fwd_b;

  // A Memory-stage producer takes priority over Writeback because it holds
  // the younger value. x0 never forwards.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic [4:0] rd_m,
    input logic [4:0] rd_w,
    input logic       wr_m,
    input logic       wr_w
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (wr_m && (rd_m != 5'd0) && (rd_m == rs)) begin
      sel = 2'b10;
    end else if (wr_w && (rd_w != 5'd0) && (rd_w == rs)) begin
      sel = 2'b01;
    end
    return sel;
  endfunction

  // Next-state logic for the memory-wait sequencer and its cycle counter.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    case (state)
      RUN: begin
        if (bus.MemReqM && !bus.MemReadyM) begin
          state_nxt    = MEM_WAIT;
          wait_cnt_nxt = 8'd0;
        end
      end
      MEM_WAIT: begin
        wait_cnt_nxt = wait_cnt + 8'd1;
        if (bus.MemReadyM) begin
          state_nxt = RUN;
        end else if (wait_cnt_nxt == WAIT_LIM) begin
          state_nxt = ERROR;
        end
      end
      default: state_nxt = ERROR;
    endcase
  end

  // Registers for the sequencer state, the wait counter and the sticky error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      wait_cnt <= 8'd0;
      mem_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (state_nxt == ERROR && state != ERROR) begin
        mem_err <= 1'b1;
      end
    end
  end

  // Stage enables and forwarding selects. A memory freeze overrides load-use
  // and redirect handling. The redirect is therefore held in Execute and acted
  // on once the access completes.
  always_comb begin
    stall_f   = 1'b0;
    stall_d   = 1'b0;
    stall_e   = 1'b0;
    stall_m   = 1'b0;
    flush_d   = 1'b0;
    flush_e   = 1'b0;
    flush_w   = 1'b0;
    fwd_a     = 2'b00;
    fwd_b     = 2'b00;
    mem_stall = (state == RUN && bus.MemReqM && !bus.MemReadyM) || (state != RUN);
    lw_stall  = bus.ResultSrcE0 && (bus.RdE != 5'd0) &&
                ((bus.RdE == bus.Rs1D) || (bus.RdE == bus.Rs2D)) && !bus.PCSrcE;
    if (!rst) begin
      fwd_a = fwd_sel(bus.Rs1E, bus.RdM, bus.RdW, bus.RegWriteM, bus.RegWriteW);
      fwd_b = fwd_sel(bus.Rs2E, bus.RdM, bus.RdW, bus.RegWriteM, bus.RegWriteW);
      if (mem_stall) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
        stall_m = 1'b1;
        flush_w = 1'b1;
      end else begin
        stall_f = lw_stall;
        stall_d = lw_stall;
        flush_d = bus.PCSrcE;
        flush_e = lw_stall || bus.PCSrcE;
      end
    end
  end

  // Saturating debug counters of stall cycles (StallF) and bubble cycles (FlushE).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_f && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (flush_e && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.StallF    = stall_f;
  assign bus.StallD    = stall_d;
  assign bus.StallE    = stall_e;
  assign bus.StallM    = stall_m;
  assign bus.FlushD    = flush_d;
  assign bus.FlushE    = flush_e;
  assign bus.FlushW    = flush_w;
  assign bus.ForwardAE = fwd_a;
  assign bus.ForwardBE = fwd_b;
  assign bus.MemErr    = mem_err;
  assign bus.StallCnt  = stall_cnt;
  assign bus.FlushCnt  = flush_cnt;
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit, built with CNT_W=4 and WAIT_MAX=16.
// Output word layout:
//   {state, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
//    ForwardAE, ForwardBE, MemErr}
module tb_hazard_ctrl_unit;
  localparam int CNT_W    = 4;
  localparam int WAIT_MAX = 16;
  localparam logic [1:0] S_RUN  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ERR  = 2'd2;

  typedef struct {
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic       ld, rwm, rww, pcs;
    logic       sf, sd, fd, fe;
    logic [1:0] fa, fb;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [13:0] exp_q[$];
  string       name_q[$];
  vec_t        tbl[$];

  hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

  hazard_ctrl_unit #(.WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock generation.
  always #5 clk = ~clk;

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [13:0] mk_exp(
    input logic [1:0] st,
    input logic sf, input logic sd, input logic se, input logic sm,
    input logic fd, input logic fe, input logic fw,
    input logic [1:0] fa, input logic [1:0] fb, input logic me
  );
    return {st, sf, sd, se, sm, fd, fe, fw, fa, fb, me};
  endfunction

  function automatic logic [13:0] frozen(input logic [1:0] st, input logic me);
    return mk_exp(st, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, me);
  endfunction

  task automatic set_pipe(
    input logic [4:0] rs1d, input logic [4:0] rs2d,
    input logic [4:0] rs1e, input logic [4:0] rs2e,
    input logic [4:0] rde, input logic [4:0] rdm, input logic [4:0] rdw,
    input logic ld, input logic rwm, input logic rww, input logic pcs
  );
    bus.Rs1D = rs1d; bus.Rs2D = rs2d; bus.Rs1E = rs1e; bus.Rs2E = rs2e;
    bus.RdE = rde; bus.RdM = rdm; bus.RdW = rdw;
    bus.ResultSrcE0 = ld; bus.RegWriteM = rwm; bus.RegWriteW = rww; bus.PCSrcE = pcs;
  endtask

  task automatic set_idle();
    set_pipe(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.MemReqM   = 1'b0;
    bus.MemReadyM = 1'b0;
  endtask

  task automatic push_exp(input string name, input logic [13:0] e);
    exp_q.push_back(e);
    name_q.push_back(name);
  endtask

  // Pops the oldest expectation and compares it with the DUT outputs at the falling edge.
  task automatic check_out();
    logic [13:0] act;
    logic [13:0] e;
    string       nm;
    @(negedge clk);
    act = {bus.dbg_state, bus.StallF, bus.StallD, bus.StallE, bus.StallM,
           bus.FlushD, bus.FlushE, bus.FlushW, bus.ForwardAE, bus.ForwardBE, bus.MemErr};
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL scoreboard_empty: got %h with no expected entry", act);
    end else begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      if (act !== e) begin
        n_err++;
        $display("FAIL %s: got %h expected %h", nm, act, e);
      end
    end
  endtask

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] e);
    n_cmp++;
    if (act !== e) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, e);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Asserts reset while driving inputs that would otherwise set every output.
  task automatic apply_reset();
    rst = 1'b1;
    set_pipe(5'd5, 5'd5, 5'd3, 5'd4, 5'd5, 5'd3, 5'd4, 1'b1, 1'b1, 1'b1, 1'b1);
    bus.MemReqM   = 1'b1;
    bus.MemReadyM = 1'b0;
    next_cycle();
    push_exp("reset_outputs", 14'd0);
    check_out();
    check_val("reset_stall_cnt", 32'(bus.StallCnt), 32'd0);
    check_val("reset_flush_cnt", 32'(bus.FlushCnt), 32'd0);
    set_idle();
    rst = 1'b0;
    next_cycle();
  endtask

  initial begin
    rst = 1'b1;
    set_idle();

    // rs1d rs2d rs1e rs2e rde rdm rdw ld rwm rww pcs | sf sd fd fe fa fb
    tbl.push_back('{5'd5, 5'd0, 5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00});
    tbl.push_back('{5'd5, 5'd0, 5'd0, 5'd0, 5'd0, 5'd5, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00});
    tbl.push_back('{5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 5'd0, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00});
    tbl.push_back('{5'd0, 5'd7, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00});
    tbl.push_back('{5'd0, 5'd0, 5'd3, 5'd0, 5'd0, 5'd3, 5'd3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00});
    tbl.push_back('{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00});
    tbl.push_back('{5'd0, 5'd0, 5'd0, 5'd4, 5'd0, 5'd4, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10});
    tbl.push_back('{5'd0, 5'd0, 5'd6, 5'd9, 5'd0, 5'd6, 5'd9, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01});
    tbl.push_back('{5'd0, 5'd0, 5'd3, 5'd3, 5'd0, 5'd3, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00});
    tbl.push_back('{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00});
    tbl.push_back('{5'd5, 5'd0, 5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00});
    tbl.push_back('{5'd5, 5'd0, 5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00});
    tbl.push_back('{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00});

    apply_reset();

    // Combinational hazard and forwarding vectors, all in RUN.
    for (int i = 0; i < tbl.size(); i++) begin
      set_pipe(tbl[i].rs1d, tbl[i].rs2d, tbl[i].rs1e, tbl[i].rs2e, tbl[i].rde,
               tbl[i].rdm, tbl[i].rdw, tbl[i].ld, tbl[i].rwm, tbl[i].rww, tbl[i].pcs);
      push_exp($sformatf("vec%0d", i),
               mk_exp(S_RUN, tbl[i].sf, tbl[i].sd, 1'b0, 1'b0, tbl[i].fd, tbl[i].fe,
                      1'b0, tbl[i].fa, tbl[i].fb, 1'b0));
      check_out();
      next_cycle();
    end
    set_idle();
    @(negedge clk);
    check_val("table_stall_cnt", 32'(bus.StallCnt), 32'd2);
    check_val("table_flush_cnt", 32'(bus.FlushCnt), 32'd4);
    next_cycle();

    // Memory wait: ready is low for three cycles, giving four frozen cycles.
    // A load-use pattern and a redirect are held in place throughout.
    apply_reset();
    set_pipe(5'd5, 5'd0, 5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    bus.MemReqM = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      bus.MemReadyM = (k == 4);
      push_exp($sformatf("mem_wait_%0d", k), frozen((k == 1) ? S_RUN : S_WAIT, 1'b0));
      check_out();
      next_cycle();
    end
    bus.MemReqM   = 1'b0;
    bus.MemReadyM = 1'b0;
    push_exp("redirect_after_wait",
             mk_exp(S_RUN, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0));
    check_out();
    next_cycle();
    set_idle();
    @(negedge clk);
    check_val("wait_stall_cnt", 32'(bus.StallCnt), 32'd4);
    check_val("wait_flush_cnt", 32'(bus.FlushCnt), 32'd1);
    next_cycle();

    // Zero-cycle access: request and ready together in RUN.
    bus.MemReqM   = 1'b1;
    bus.MemReadyM = 1'b1;
    push_exp("zero_cycle_access", mk_exp(S_RUN, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0));
    check_out();
    next_cycle();
    set_idle();
    push_exp("after_zero_cycle", 14'd0);
    check_out();
    next_cycle();

    // Reset in the middle of an access discards the access.
    bus.MemReqM = 1'b1;
    push_exp("mid_access_req", frozen(S_RUN, 1'b0));
    check_out();
    next_cycle();
    push_exp("mid_access_wait", frozen(S_WAIT, 1'b0));
    check_out();
    apply_reset();
    push_exp("after_mid_reset", 14'd0);
    check_out();
    next_cycle();

    // Timeout: ready never rises. After 16 MEM_WAIT cycles the sequencer goes to ERROR.
    // The 4-bit stall counter saturates along the way.
    bus.MemReqM   = 1'b1;
    bus.MemReadyM = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      push_exp($sformatf("timeout_%0d", k),
               frozen((k == 1) ? S_RUN : ((k <= WAIT_MAX + 1) ? S_WAIT : S_ERR),
                      (k >= WAIT_MAX + 2)));
      check_out();
      next_cycle();
    end
    bus.MemReadyM = 1'b1;
    push_exp("error_holds", frozen(S_ERR, 1'b1));
    check_out();
    check_val("stall_cnt_saturated", 32'(bus.StallCnt), 32'd15);
    check_val("flush_cnt_in_error", 32'(bus.FlushCnt), 32'd0);
    next_cycle();
    apply_reset();
    push_exp("after_error_reset", 14'd0);
    check_out();
    next_cycle();

    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
